// File: rtl/cs_window_avg.sv
// Sliding-window averager: keeps the last 2^K+1 samples and emits either an
// approximate average (mean anchored on a window sample) or the plain scaled mean.
module cs_window_lane #(
    parameter int DATA_W = 8,
    parameter int K      = 3
) (
    input  logic [DATA_W-1:0] sample_i,
    input  logic [DATA_W+K:0] sum_i,
    output logic              fit_o
);
    logic [DATA_W+K:0] scaled;

    // WIN*sample as shift-and-add; WIN*max sample still fits in the sum width
    assign scaled = {1'b0, sample_i, {K{1'b0}}} + (DATA_W+K+1)'(sample_i);
    assign fit_o  = (scaled <= sum_i);
endmodule

module cs_window_avg #(
    parameter int DATA_W = 8,
    parameter int K      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] X,
    input  logic              in_valid,
    input  logic              mode,
    input  logic              flush,
    output logic [DATA_W+1:0] Y,
    output logic              out_valid
);
    localparam int WIN = (1 << K) + 1;
    localparam int SW  = DATA_W + K + 1;
    localparam int CW  = $clog2(WIN + 1);

    logic [WIN-1:0][DATA_W-1:0] win_q, win_d;
    logic [SW-1:0]              sum_q, sum_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       pend_q, pend_d;
    logic                       mode_q, mode_d;
    logic [DATA_W+1:0]          y_q, y_d;
    logic                       ov_q, ov_d;

    logic [WIN-1:0]             fit;
    logic [DATA_W-1:0]          xa;
    logic [SW-1:0]              wxa;
    logic [SW:0]                approx_sum;
    logic [DATA_W+1:0]          y_approx, y_mean;

    for (genvar i = 0; i < WIN; i++) begin : g_lane
        cs_window_lane #(.DATA_W(DATA_W), .K(K)) u_lane (
            .sample_i (win_q[i]),
            .sum_i    (sum_q),
            .fit_o    (fit[i])
        );
    end

    // Largest sample not above the mean; the window minimum always qualifies
    always_comb begin
        xa = '0;
        for (int i = 0; i < WIN; i++) begin
            if (fit[i] && (win_q[i] > xa)) xa = win_q[i];
        end
    end

    assign wxa        = {1'b0, xa, {K{1'b0}}} + SW'(xa);
    assign approx_sum = {1'b0, sum_q} + {1'b0, wxa};
    assign y_approx   = (DATA_W+2)'(approx_sum >> K);
    assign y_mean     = (DATA_W+2)'({sum_q, 1'b0} >> K);

    always_comb begin
        win_d  = win_q;
        sum_d  = sum_q;
        cnt_d  = cnt_q;
        pend_d = 1'b0;
        mode_d = mode_q;
        if (flush) begin
            win_d = '0;
            sum_d = '0;
            cnt_d = '0;
        end else if (in_valid) begin
            win_d = {win_q[WIN-2:0], X};
            sum_d = sum_q + SW'(X) - SW'(win_q[WIN-1]);
            if (cnt_q != CW'(WIN)) cnt_d = cnt_q + CW'(1);
            pend_d = (cnt_d == CW'(WIN));
            mode_d = mode;
        end
    end

    // Result stage works on the window as it stands one cycle after acceptance
    always_comb begin
        y_d  = y_q;
        ov_d = 1'b0;
        if (pend_q) begin
            y_d  = mode_q ? y_mean : y_approx;
            ov_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q  <= '0;
            sum_q  <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            mode_q <= 1'b0;
            y_q    <= '0;
            ov_q   <= 1'b0;
        end else begin
            win_q  <= win_d;
            sum_q  <= sum_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            mode_q <= mode_d;
            y_q    <= y_d;
            ov_q   <= ov_d;
        end
    end

    assign Y         = y_q;
    assign out_valid = ov_q;
endmodule
